// File: rtl/br_resolve.sv
// LC-3 branch resolution: captures IR/PC/NZP on START, evaluates BEN and PC+SEXT(offset),
// and presents a one-cycle DONE pulse. Define BR_STATS_EN to add branch/taken counters.
module br_resolve #(
  parameter int DATA_W   = 16,
  parameter int OFFSET_W = 9
) (
  input  logic              i_Clk,
  input  logic              i_Rst_n,
  input  logic              START,
  input  logic [DATA_W-1:0] IR,
  input  logic [DATA_W-1:0] PC_IN,
  input  logic              N_IN,
  input  logic              Z_IN,
  input  logic              P_IN,
  output logic              BUSY,
  output logic              DONE,
  output logic              BEN,
  output logic              LD_PC,
  output logic [DATA_W-1:0] TARGET,
  output logic              NOT_BR
`ifdef BR_STATS_EN
  ,
  input  logic              STATS_CLR,
  output logic [15:0]       TAKEN_CNT,
  output logic [15:0]       BR_CNT
`endif
);

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_EVAL   = 2'd1,
    S_RESULT = 2'd2
  } state_t;

  state_t              state_q;
  logic [DATA_W-1:0]   ir_q;
  logic [DATA_W-1:0]   pc_q;
  logic                n_q, z_q, p_q;
  logic                busy_q, done_q, ben_q, ldpc_q, notbr_q;
  logic [DATA_W-1:0]   target_q;

  logic                ben_d, notbr_d;
  logic [DATA_W-1:0]   target_d;

  function automatic logic signed [DATA_W-1:0] sext_off(input logic [OFFSET_W-1:0] off);
    return {{(DATA_W-OFFSET_W){off[OFFSET_W-1]}}, off};
  endfunction

  // Evaluated from the START-cycle captures so later flag changes cannot leak in
  always_comb begin
    notbr_d  = (ir_q[DATA_W-1 -: 4] != 4'b0000);
    ben_d    = ~notbr_d & ((ir_q[11] & n_q) | (ir_q[10] & z_q) | (ir_q[9] & p_q));
    target_d = pc_q + sext_off(ir_q[OFFSET_W-1:0]);
  end

  always_ff @(posedge i_Clk or negedge i_Rst_n) begin
    if (!i_Rst_n) begin
      state_q  <= S_IDLE;
      ir_q     <= '0;
      pc_q     <= '0;
      n_q      <= 1'b0;
      z_q      <= 1'b0;
      p_q      <= 1'b0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
      ben_q    <= 1'b0;
      ldpc_q   <= 1'b0;
      notbr_q  <= 1'b0;
      target_q <= '0;
    end else begin
      case (state_q)
        S_IDLE: begin
          done_q <= 1'b0;
          ldpc_q <= 1'b0;
          if (START) begin
            ir_q    <= IR;
            pc_q    <= PC_IN;
            n_q     <= N_IN;
            z_q     <= Z_IN;
            p_q     <= P_IN;
            busy_q  <= 1'b1;
            state_q <= S_EVAL;
          end
        end
        S_EVAL: begin
          ben_q    <= ben_d;
          ldpc_q   <= ben_d;
          notbr_q  <= notbr_d;
          target_q <= target_d;
          done_q   <= 1'b1;
          state_q  <= S_RESULT;
        end
        S_RESULT: begin
          done_q  <= 1'b0;
          ldpc_q  <= 1'b0;
          busy_q  <= 1'b0;
          state_q <= S_IDLE;
        end
        default: begin
          done_q  <= 1'b0;
          ldpc_q  <= 1'b0;
          busy_q  <= 1'b0;
          state_q <= S_IDLE;
        end
      endcase
    end
  end

  assign BUSY   = busy_q;
  assign DONE   = done_q;
  assign BEN    = ben_q;
  assign LD_PC  = ldpc_q;
  assign TARGET = target_q;
  assign NOT_BR = notbr_q;

`ifdef BR_STATS_EN
  logic [15:0] taken_cnt_q, br_cnt_q;

  function automatic logic [15:0] sat_inc(input logic [15:0] v);
    return (v == 16'hFFFF) ? v : v + 16'd1;
  endfunction

  always_ff @(posedge i_Clk or negedge i_Rst_n) begin
    if (!i_Rst_n) begin
      taken_cnt_q <= '0;
      br_cnt_q    <= '0;
    end else if (STATS_CLR) begin
      taken_cnt_q <= '0;
      br_cnt_q    <= '0;
    end else if (done_q) begin
      if (!notbr_q) br_cnt_q    <= sat_inc(br_cnt_q);
      if (ldpc_q)   taken_cnt_q <= sat_inc(taken_cnt_q);
    end
  end

  assign TAKEN_CNT = taken_cnt_q;
  assign BR_CNT    = br_cnt_q;
`endif

endmodule

// File: tb/tb_br_resolve.sv
// Scoreboard bench for br_resolve: driver pushes expected results, negedge monitor pops on DONE.
module tb_br_resolve;
  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        start = 1'b0;
  logic [15:0] ir = '0, pc_in = '0;
  logic        n_in = 1'b0, z_in = 1'b0, p_in = 1'b0;
  logic        busy, done, ben, ld_pc, not_br;
  logic [15:0] target;
`ifdef BR_STATS_EN
  logic        stats_clr = 1'b0;
  logic [15:0] taken_cnt, br_cnt;
`endif

  br_resolve #(.DATA_W(16), .OFFSET_W(9)) dut (
    .i_Clk(clk), .i_Rst_n(rst_n), .START(start), .IR(ir), .PC_IN(pc_in),
    .N_IN(n_in), .Z_IN(z_in), .P_IN(p_in),
    .BUSY(busy), .DONE(done), .BEN(ben), .LD_PC(ld_pc), .TARGET(target), .NOT_BR(not_br)
`ifdef BR_STATS_EN
    , .STATS_CLR(stats_clr), .TAKEN_CNT(taken_cnt), .BR_CNT(br_cnt)
`endif
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        ben;
    logic [15:0] tgt;
    logic        nb;
    int          cyc;
  } exp_t;

  exp_t        q[$];
  int          cyc = 0;
  int          last_e = -100;
  logic        last_ben = 1'b0, last_nb = 1'b0;
  logic [15:0] last_tgt = '0;
  int          n_tests = 0, n_fail = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    n_tests++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, req, cyc);
    end
  endtask

  // Reference: LC-3 BR semantics with plain integer arithmetic
  function automatic exp_t model(input logic [15:0] i, input logic [15:0] p,
                                 input logic n, input logic z, input logic pp);
    exp_t e;
    int   off;
    bit   is_br;
    is_br = (i >> 12) == 0;
    off   = int'(i) % 512;
    if (off >= 256) off = off - 512;
    e.nb  = !is_br;
    e.ben = is_br && ((i[11] && n) || (i[10] && z) || (i[9] && pp));
    e.tgt = 16'((int'(p) + off + 65536) % 65536);
    e.cyc = 0;
    return e;
  endfunction

  task automatic tick(input int k = 1);
    repeat (k) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic scramble();
    ir    = 16'($urandom);
    pc_in = 16'($urandom);
    n_in  = 1'($urandom);
    z_in  = 1'($urandom);
    p_in  = 1'($urandom);
  endtask

  // Requests are accepted only when at least 3 edges separate them from the last accepted one
  task automatic issue(input logic [15:0] i, input logic [15:0] p,
                       input logic n, input logic z, input logic pp);
    exp_t e;
    start = 1'b1; ir = i; pc_in = p; n_in = n; z_in = z; p_in = pp;
    e = model(i, p, n, z, pp);
    tick();
    if (cyc - last_e >= 3) begin
      e.cyc  = cyc + 1;
      last_e = cyc;
      q.push_back(e);
    end
    start = 1'b0;
    scramble();
  endtask

  task automatic chk_zero(input string tag);
    chk({tag, "_busy"},   busy,   0);
    chk({tag, "_done"},   done,   0);
    chk({tag, "_ben"},    ben,    0);
    chk({tag, "_ld_pc"},  ld_pc,  0);
    chk({tag, "_not_br"}, not_br, 0);
    chk({tag, "_target"}, target, 0);
  endtask

  always @(negedge clk) begin
    if (rst_n) begin
      chk("busy", busy, (cyc == last_e || cyc == last_e + 1));
      if (done) begin
        if (q.size() == 0) begin
          chk("spurious_done", done, 0);
        end else begin
          exp_t e;
          e = q.pop_front();
          chk("done_cycle", cyc, e.cyc);
          chk("ben", ben, e.ben);
          chk("ld_pc", ld_pc, e.ben);
          chk("target", target, e.tgt);
          chk("not_br", not_br, e.nb);
          last_ben = e.ben; last_tgt = e.tgt; last_nb = e.nb;
        end
      end else begin
        chk("ld_pc_idle", ld_pc, 0);
        chk("ben_hold", ben, last_ben);
        chk("target_hold", target, last_tgt);
        chk("not_br_hold", not_br, last_nb);
        if (q.size() > 0 && q[0].cyc < cyc) begin
          chk("missed_done", 0, 1);
          void'(q.pop_front());
        end
      end
    end
  end

  initial begin
    #2;
    chk_zero("reset");
    tick(2);
    rst_n = 1'b1;
    tick(2);

    // Reset during EVAL aborts the request
    issue(16'h0E05, 16'h3000, 1, 0, 0);
    #1;
    rst_n = 1'b0;
    q.delete();
    last_e = -100; last_ben = 1'b0; last_tgt = '0; last_nb = 1'b0;
    #1;
    chk_zero("abort");
    tick();
    rst_n = 1'b1;
    tick(4);

    issue(16'h0805, 16'h3001, 1, 0, 0); tick(3);   // taken, 3006
    issue(16'h0805, 16'h3001, 0, 1, 0); tick(3);   // not taken
    issue(16'h0FFF, 16'h0000, 0, 0, 1); tick(3);   // wrap to FFFF
    issue(16'h0FFF, 16'hFFFF, 0, 0, 0); tick(3);   // no flags
    issue(16'h0100, 16'hFF80, 1, 1, 1); tick(3);   // NOP mask, offset -256
    issue(16'h00FF, 16'hFFF0, 1, 1, 1); tick(3);   // NOP mask, forward wrap
    issue(16'h0A00, 16'h1234, 1, 1, 1); tick(3);   // multiple flags
    issue(16'h1021, 16'h4000, 0, 0, 1); tick(3);   // ADD: not a branch
    issue(16'h0805, 16'h3001, 1, 0, 0);            // back-to-back: second ignored
    issue(16'h0E10, 16'h5000, 1, 1, 1);
    issue(16'h0E10, 16'h5000, 1, 1, 1);            // arrives in RESULT: ignored
    issue(16'h0E20, 16'h6000, 0, 0, 1);            // first IDLE cycle: accepted
    tick(4);

    for (int k = 0; k < 300; k++) begin
      logic [15:0] r;
      r = 16'($urandom);
      if ($urandom_range(0, 2) != 0) r[15:12] = 4'b0000;
      issue(r, 16'($urandom), 1'($urandom), 1'($urandom), 1'($urandom));
      tick($urandom_range(0, 3));
    end
    tick(5);

`ifdef BR_STATS_EN
    stats_clr = 1'b1; tick(); stats_clr = 1'b0;
    for (int k = 0; k < 3; k++) begin issue(16'h0805, 16'h3001, 1, 0, 0); tick(3); end
    for (int k = 0; k < 2; k++) begin issue(16'h0805, 16'h3001, 0, 1, 0); tick(3); end
    issue(16'h1021, 16'h3001, 1, 1, 1); tick(3);
    tick(2);
    chk("br_cnt", br_cnt, 5);
    chk("taken_cnt", taken_cnt, 3);
    stats_clr = 1'b1; tick(); stats_clr = 1'b0;
    chk("br_cnt_clr", br_cnt, 0);
    chk("taken_cnt_clr", taken_cnt, 0);
`endif

    chk("queue_drained", q.size(), 0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1);
  end
endmodule
